// File: rtl/idvr_shift_iter.sv
// Iterative shifter/rotator: accepts one operand, shifts or rotates it by at most
// STEP bits per cycle until the requested amount is consumed, then holds the result.
module idvr_shift_iter #(
    parameter int W    = 8,
    parameter int TW   = 4,
    parameter int STEP = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  I,
    input  logic [TW-1:0] shamt,
    input  logic [2:0]    S,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  O,
    output logic          Err,
    output logic [1:0]    dbg_state
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready. The block
    // never offers both in the same cycle, so a result and a new request cannot
    // transfer on the same edge. abort overrides both.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] M_SLL = 3'b000;
    localparam logic [2:0] M_SRL = 3'b001;
    localparam logic [2:0] M_SRA = 3'b011;
    localparam logic [2:0] M_ROL = 3'b100;
    localparam logic [2:0] M_ROR = 3'b101;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [TW-1:0] rem_q, rem_d;
    logic [2:0]    mode_q, mode_d;
    logic          err_q, err_d;

    logic [TW-1:0] amt;
    logic [TW-1:0] rot;
    logic [W-1:0]  step_res;
    logic          s_legal;

    always_comb begin
        s_legal = (S == M_SLL) || (S == M_SRL) || (S == M_SRA) ||
                  (S == M_ROL) || (S == M_ROR);
    end

    // Per-cycle step: amt = min(rem, STEP). When rem >= STEP, STEP fits in TW bits.
    always_comb begin
        amt = (32'(rem_q) < STEP) ? rem_q : TW'(STEP);
        rot = TW'(32'(amt) % W);
        step_res = acc_q;
        case (mode_q)
            M_SLL:   step_res = acc_q << amt;
            M_SRL:   step_res = acc_q >> amt;
            M_SRA:   step_res = $signed(acc_q) >>> amt;
            M_ROL:   step_res = (acc_q << rot) | (acc_q >> (W - 32'(rot)));
            M_ROR:   step_res = (acc_q >> rot) | (acc_q << (W - 32'(rot)));
            default: step_res = acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        err_d   = err_q;
        if (abort) begin
            state_d = IDLE;
            acc_d   = '0;
            rem_d   = '0;
            mode_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_d  = I;
                        rem_d  = shamt;
                        mode_d = S;
                        if (!s_legal) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            err_d   = 1'b0;
                            state_d = (shamt == '0) ? DONE : BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_d = step_res;
                    rem_d = rem_q - amt;
                    if (rem_d == '0) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        rem_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    // Result and flag are only visible while the result is being offered.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign O         = out_valid ? acc_q : '0;
    assign Err       = out_valid & err_q;
    assign dbg_state = state_q;

endmodule

// File: doc/idvr_shift_iter.md
IDVR_SHIFT_ITER -- requirements
Module: idvr_shift_iter

Interface
REQ-001 SHALL have parameter W, default 8: data width in bits, W >= 2.
REQ-002 SHALL have parameter TW, default 4: shift-amount width in bits.
REQ-003 SHALL have parameter STEP, default 2: maximum bits shifted per cycle, 1 <= STEP <= W.
REQ-004 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  request valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a request.
REQ-008 SHALL have port I  input  W  operand.
REQ-009 SHALL have port shamt  input  TW  shift amount, unsigned.
REQ-010 SHALL have port S  input  3  mode: 000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR; 010, 110, 111 illegal.
REQ-011 SHALL have port abort  input  1  synchronous cancel of the current operation.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port O  output  W  result.
REQ-015 SHALL have port Err  output  1  illegal mode flag for the current result.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-017 SHALL accept a request on a rising edge when in_valid && in_ready, and register I into acc, shamt into rem, and S into mode.
REQ-018 SHALL, on accept with an illegal S, go to DONE with acc = I and Err = 1.
REQ-019 SHALL, on accept with legal S and shamt == 0, go to DONE with acc = I and Err = 0.
REQ-020 SHALL, on accept with legal S and shamt != 0, go to BUSY with Err = 0.
REQ-021 SHALL, each BUSY cycle, set amt = min(rem, STEP), shift or rotate acc by amt per mode, and set rem = rem - amt.
REQ-022 SHALL go from BUSY to DONE on the edge where rem reaches 0.
REQ-023 SHALL give latency from the accept edge to out_valid rising of exactly 1 + ceil(shamt/STEP) cycles for legal modes, and 1 cycle for shamt == 0 or an illegal mode.
REQ-024 SHALL zero-fill for SLL and SRL and fill with acc[W-1] for SRA.
REQ-025 SHALL handle shamt >= W without special casing: SLL and SRL yield 0, SRA yields all sign bits, and ROL/ROR yield a rotation by shamt mod W.
REQ-026 SHALL, in DONE, drive O = acc and Err, holding both stable until out_ready == 1.
REQ-027 SHALL, in DONE with out_ready == 1, go to IDLE on that edge, with no same-cycle new accept.
REQ-028 SHALL drive O = 0 and Err = 0 in IDLE and BUSY.
REQ-029 SHALL, when abort == 1 in any state, go to IDLE on the next edge, discarding acc and rem; abort has priority over accept and over DONE completion.
REQ-030 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.

Reset
REQ-031 SHALL, while rst == 1, immediately force state = IDLE, acc = 0, rem = 0, mode = 0, Err = 0, O = 0, and out_valid = 0, with in_ready = 1.
REQ-032 SHALL perform no transfer while rst == 1, and SHALL accept the first request on the first rising edge after rst deasserts.
REQ-033 SHALL, when reset is asserted mid-BUSY or mid-DONE, lose the operation and produce no result.

Verification (W=8, TW=4, STEP=2; accept edge = cycle 0)
REQ-034 SHALL cover: SLL, I=0x81, shamt=3 -> out_valid at cycle 3, O=0x08, Err=0.
REQ-035 SHALL cover: SRA, I=0x90, shamt=15 -> out_valid at cycle 9, O=0xFF; and SRL, I=0x90, shamt=15 -> O=0x00 at cycle 9.
REQ-036 SHALL cover: ROR, I=0x01, shamt=9 -> out_valid at cycle 6, O=0x80; and ROL, I=0x81, shamt=1 -> O=0x03 at cycle 2.
REQ-037 SHALL cover: S=010, I=0x5A, shamt=7 -> out_valid at cycle 1, O=0x5A, Err=1.
REQ-038 SHALL cover: out_ready low for 4 cycles in DONE -> O and Err stable, in_ready=0, and a new in_valid is ignored; one cycle after out_ready=1, in_ready=1.
REQ-039 SHALL cover: abort, or async rst pulse, during BUSY of SLL shamt=8 -> IDLE and outputs 0 with no out_valid; the next request, SRL, I=0x80, shamt=1 -> O=0x40 at cycle 2.
